arith_seq_ctrl: RTL and testbench

- Sequential front-end for the combinational 8-bit arithmetic unit (divide/add/subtract/multiply, 2-bit select P, active-low enable).
- Accepts opcode and operands over a valid/ready handshake, then decodes and screens them: illegal opcode and divide-by-zero are rejected.
- Drives the unit for exactly one enabled cycle and registers its 16-bit result together with a sign flag and an error flag.
- Presents the result downstream over a second valid/ready handshake, and counts completed operations.

---
 rtl/arith_pkg.sv | 38 +++
 rtl/arith_op_decode.sv | 41 ++++
 rtl/arith_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_arith_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_pkg
//  Description : Shared opcodes, arithmetic-unit select codes, FSM state
//                encoding and the opcode legality helper for arith_seq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    // Request opcodes; every other 4-bit value is illegal.
    localparam logic [3:0] OP_DIV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;

    // Select codes understood by the combinational arithmetic unit.
    localparam logic [1:0] P_DIV = 2'b00;
    localparam logic [1:0] P_ADD = 2'b01;
    localparam logic [1:0] P_SUB = 2'b10;
    localparam logic [1:0] P_MUL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_legal(input logic [3:0] opcode);
        logic legal;
        case (opcode)
            OP_DIV, OP_ADD, OP_SUB, OP_MUL: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage : arith_pkg
`default_nettype wire

// File: rtl/arith_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : arith_op_decode
//  Description : Combinational opcode decoder. Maps a request opcode onto the
//                arithmetic-unit select and screens it for illegal opcodes
//                and divide-by-zero.
//  Ports       : opcode_i   - request opcode
//                b_i        - operand B (divisor for divide)
//                p_o        - arithmetic-unit select (00 for illegal opcodes)
//                legal_o    - opcode is one of div/add/sub/mul
//                div_zero_o - divide requested with B == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_op_decode
    import arith_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    opcode_i,
    input  logic [DW-1:0] b_i,
    output logic [1:0]    p_o,
    output logic          legal_o,
    output logic          div_zero_o
);

    always_comb begin
        p_o = P_DIV;
        case (opcode_i)
            OP_DIV:  p_o = P_DIV;
            OP_ADD:  p_o = P_ADD;
            OP_SUB:  p_o = P_SUB;
            OP_MUL:  p_o = P_MUL;
            default: p_o = P_DIV;
        endcase
    end

    assign legal_o    = is_legal(opcode_i);
    assign div_zero_o = (opcode_i == OP_DIV) && (b_i == '0);

endmodule : arith_op_decode
`default_nettype wire

// File: rtl/arith_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arith_seq_ctrl
//  Description : Sequential front-end for an 8-bit combinational arithmetic
//                unit. Accepts a request over valid/ready, rejects illegal
//                opcodes and divide-by-zero, enables the unit for exactly one
//                cycle, registers the result with sign/error flags and hands
//                it downstream over a second valid/ready. Counts completions.
//  Ports       : clk, rst_n                - clock, async active-low reset
//                in_valid/in_ready         - request handshake
//                in_opcode, in_a, in_b     - request payload
//                au_a, au_b, au_p, au_en_n - drive to the arithmetic unit
//                au_y                      - arithmetic unit result
//                out_valid/out_ready       - result handshake
//                out_res, out_sign, out_err- registered result and flags
//                op_count                  - completed operations (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_seq_ctrl
    import arith_pkg::*;
#(
    parameter int DW = 8,
    parameter int RW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_opcode,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic [DW-1:0] au_a,
    output logic [DW-1:0] au_b,
    output logic [1:0]    au_p,
    output logic          au_en_n,
    input  logic [RW-1:0] au_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_res,
    output logic          out_sign,
    output logic          out_err,
    output logic [CW-1:0] op_count
);

    state_e        state_q,    state_d;
    logic [DW-1:0] au_a_q,     au_a_d;
    logic [DW-1:0] au_b_q,     au_b_d;
    logic [1:0]    au_p_q,     au_p_d;
    logic          au_en_n_q,  au_en_n_d;
    logic [RW-1:0] out_res_q,  out_res_d;
    logic          out_sign_q, out_sign_d;
    logic          out_err_q,  out_err_d;
    logic [CW-1:0] op_count_q, op_count_d;

    logic [1:0]    dec_p;
    logic          dec_legal;
    logic          dec_div_zero;

    arith_op_decode #(
        .DW (DW)
    ) u_decode (
        .opcode_i   (in_opcode),
        .b_i        (in_b),
        .p_o        (dec_p),
        .legal_o    (dec_legal),
        .div_zero_o (dec_div_zero)
    );

    // in_ready is gated by rst_n so it drops the moment reset asserts,
    // without waiting for the state register.
    assign in_ready = (state_q == ST_IDLE) && rst_n;

    always_comb begin
        state_d    = state_q;
        au_a_d     = au_a_q;
        au_b_d     = au_b_q;
        au_p_d     = au_p_q;
        au_en_n_d  = au_en_n_q;
        out_res_d  = out_res_q;
        out_sign_d = out_sign_q;
        out_err_d  = out_err_q;
        op_count_d = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    au_a_d = in_a;
                    au_b_d = in_b;
                    au_p_d = dec_p;
                    if (!dec_legal || dec_div_zero) begin
                        // Rejected requests skip EXEC; the unit is never enabled.
                        state_d    = ST_DONE;
                        out_res_d  = '0;
                        out_sign_d = 1'b0;
                        out_err_d  = 1'b1;
                    end else begin
                        state_d   = ST_EXEC;
                        au_en_n_d = 1'b0;
                    end
                end
            end
            ST_EXEC: begin
                // au_y is only trusted here, while the unit is enabled.
                out_res_d  = au_y;
                out_sign_d = (au_p_q == P_SUB) && (au_a_q < au_b_q);
                out_err_d  = 1'b0;
                au_en_n_d  = 1'b1;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d    = ST_IDLE;
                    op_count_d = op_count_q + CW'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                au_en_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            au_a_q     <= '0;
            au_b_q     <= '0;
            au_p_q     <= P_DIV;
            au_en_n_q  <= 1'b1;
            out_res_q  <= '0;
            out_sign_q <= 1'b0;
            out_err_q  <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            au_a_q     <= au_a_d;
            au_b_q     <= au_b_d;
            au_p_q     <= au_p_d;
            au_en_n_q  <= au_en_n_d;
            out_res_q  <= out_res_d;
            out_sign_q <= out_sign_d;
            out_err_q  <= out_err_d;
            op_count_q <= op_count_d;
        end
    end

    assign au_a      = au_a_q;
    assign au_b      = au_b_q;
    assign au_p      = au_p_q;
    assign au_en_n   = au_en_n_q;
    assign out_valid = (state_q == ST_DONE);
    assign out_res   = out_res_q;
    assign out_sign  = out_sign_q;
    assign out_err   = out_err_q;
    assign op_count  = op_count_q;

endmodule : arith_seq_ctrl
`default_nettype wire

// File: tb/tb_arith_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arith_seq_ctrl
//  Description : Self-checking bench for arith_seq_ctrl with a behavioural
//                model of the external arithmetic unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_seq_ctrl;

    localparam int DW = 8;
    localparam int RW = 16;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] au_a;
    logic [DW-1:0] au_b;
    logic [1:0]    au_p;
    logic          au_en_n;
    logic [RW-1:0] au_y;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_res;
    logic          out_sign;
    logic          out_err;
    logic [CW-1:0] op_count;

    arith_seq_ctrl #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_a      (in_a),
        .in_b      (in_b),
        .au_a      (au_a),
        .au_b      (au_b),
        .au_p      (au_p),
        .au_en_n   (au_en_n),
        .au_y      (au_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_sign  (out_sign),
        .out_err   (out_err),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic unit model: real result while enabled, noise otherwise so a
    // design that samples au_y outside EXEC is caught.
    logic [RW-1:0] junk;
    always @(negedge clk) junk = RW'($urandom);

    always_comb begin
        au_y = junk;
        if (!au_en_n) begin
            case (au_p)
                2'b00:   au_y = (au_b == 0) ? 16'hFFFF : RW'(au_a) / RW'(au_b);
                2'b01:   au_y = RW'(au_a) + RW'(au_b);
                2'b10:   au_y = (au_a >= au_b) ? RW'(au_a) - RW'(au_b) : RW'(au_b) - RW'(au_a);
                default: au_y = RW'(au_a) * RW'(au_b);
            endcase
        end
    end

    // Enable-cycle counter: reads au_en_n before the edge updates it.
    int en_cnt = 0;
    always @(posedge clk) if (!au_en_n) en_cnt = en_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour computed directly from the operation rules.
    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] res, output logic sgn, output logic err);
        int ia = a;
        int ib = b;
        res = 0; sgn = 0; err = 0;
        case (op)
            4'd1: if (ib == 0) err = 1; else res = 16'(ia / ib);
            4'd2: res = 16'(ia + ib);
            4'd3: begin res = 16'((ia >= ib) ? ia - ib : ib - ia); sgn = (ia < ib); end
            4'd4: res = 16'(ia * ib);
            default: err = 1;
        endcase
    endtask

    function automatic logic [1:0] sel_of(input logic [3:0] op);
        return 2'(op - 4'd1);
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] e_res, input logic e_sign, input logic e_err,
                          input int hold);
        int k;
        int base;
        logic [15:0] held;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 1);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b0;
        base = en_cnt;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_opcode = 4'($urandom);
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        k = 0;
        while (!out_valid && k < 8) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", 32'(k), e_err ? 0 : 1);
        check("out_res", 32'(out_res), 32'(e_res));
        check("out_sign", 32'(out_sign), 32'(e_sign));
        check("out_err", 32'(out_err), 32'(e_err));
        check("en_pulses", 32'(en_cnt - base), e_err ? 0 : 1);
        check("au_en_n_done", 32'(au_en_n), 1);
        if (!e_err) check("au_p", 32'(au_p), 32'(sel_of(op)));
        held = out_res;
        // Stall downstream while a fresh request knocks at the input.
        in_valid  = (hold > 0);
        in_opcode = 4'b0010;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 1);
            check("hold_res", 32'(out_res), 32'(held));
            check("hold_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_count = (exp_count + 1) % 256;
        check("post_valid", 32'(out_valid), 0);
        check("op_count", 32'(op_count), 32'(exp_count));
        check("post_ready", 32'(in_ready), 1);
        check("post_res_kept", 32'(out_res), 32'(held));
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        sgn;
        logic        err;
        int          hold;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{4'b0010, 8'd200, 8'd100, 16'd300,   1'b0, 1'b0, 0};
        vecs[1] = '{4'b0011, 8'd5,   8'd9,   16'd4,     1'b1, 1'b0, 0};
        vecs[2] = '{4'b0011, 8'd9,   8'd9,   16'd0,     1'b0, 1'b0, 0};
        vecs[3] = '{4'b0100, 8'd255, 8'd255, 16'd65025, 1'b0, 1'b0, 5};
        vecs[4] = '{4'b0001, 8'd100, 8'd0,   16'd0,     1'b0, 1'b1, 2};
        vecs[5] = '{4'b0001, 8'd100, 8'd7,   16'd14,    1'b0, 1'b0, 0};
        vecs[6] = '{4'b0111, 8'd3,   8'd4,   16'd0,     1'b0, 1'b1, 0};
        vecs[7] = '{4'b0000, 8'd3,   8'd4,   16'd0,     1'b0, 1'b1, 0};
        vecs[8] = '{4'b1111, 8'd1,   8'd1,   16'd0,     1'b0, 1'b1, 1};
        vecs[9] = '{4'b0011, 8'd0,   8'd255, 16'd255,   1'b1, 1'b0, 0};

        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
        #22;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_au_en_n", 32'(au_en_n), 1);
        check("rst_au_p", 32'(au_p), 0);
        check("rst_au_ab", 32'({au_a, au_b}), 0);
        check("rst_out", 32'({out_res, out_sign, out_err}), 0);
        check("rst_count", 32'(op_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].sgn, vecs[i].err, vecs[i].hold);

        // 256 randomized back-to-back operations against the reference model.
        begin
            int start;
            start = exp_count;
            for (int n = 0; n < 256; n++) begin
                logic [3:0]  op;
                logic [7:0]  a, b;
                logic [15:0] r;
                logic        s, e;
                op = 4'($urandom_range(0, 7));
                a  = 8'($urandom);
                b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                model(op, a, b, r, s, e);
                run_op(op, a, b, r, s, e, int'($urandom_range(0, 1)));
            end
            check("count_wrap", 32'(op_count), 32'(start));
        end

        // Async reset while mul 12,12 is executing.
        @(negedge clk);
        in_valid = 1'b1; in_opcode = 4'b0100; in_a = 8'd12; in_b = 8'd12;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("exec_en_low", 32'(au_en_n), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 0);
        check("abort_en_n", 32'(au_en_n), 1);
        check("abort_count", 32'(op_count), 0);
        check("abort_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        run_op(4'b0010, 8'd1, 8'd1, 16'd2, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_arith_seq_ctrl
`default_nettype wire
